// File: rtl/spi_flash_okuyucu_if.sv
// rtl/spi_flash_okuyucu_if.sv - register request/response bus between the flash reader and the SPI controller
interface spi_flash_okuyucu_if #(
    parameter int ADRES_BIT = 32,
    parameter int VERI_BIT  = 32
) ();
    logic [ADRES_BIT-1:0] cek_adres;
    logic [VERI_BIT-1:0]  cek_veri;
    logic                 cek_yaz;
    logic                 cek_gecerli;
    logic                 cek_hazir;
    logic [VERI_BIT-1:0]  spi_veri;
    logic                 spi_gecerli;
    logic                 spi_hazir;

    modport master (
        output cek_adres, cek_veri, cek_yaz, cek_gecerli, spi_hazir,
        input  cek_hazir, spi_veri, spi_gecerli
    );

    modport slave (
        input  cek_adres, cek_veri, cek_yaz, cek_gecerli, spi_hazir,
        output cek_hazir, spi_veri, spi_gecerli
    );
endinterface

// File: rtl/spi_flash_okuyucu.sv
// rtl/spi_flash_okuyucu.sv - sequencer running an SPI-flash READ (0x03) through the SPI controller register port
`ifndef SPI_BASE_ADDR
`define SPI_BASE_ADDR 32'h4000_0000
`endif
`ifndef SPI_CTRL_REG
`define SPI_CTRL_REG  (`SPI_BASE_ADDR | 32'h00)
`endif
`ifndef SPI_WDATA_REG
`define SPI_WDATA_REG (`SPI_BASE_ADDR | 32'h08)
`endif
`ifndef SPI_RDATA_REG
`define SPI_RDATA_REG (`SPI_BASE_ADDR | 32'h0C)
`endif
`ifndef SPI_CMD_REG
`define SPI_CMD_REG   (`SPI_BASE_ADDR | 32'h10)
`endif

module spi_flash_okuyucu #(
    parameter logic [15:0] SCK_DIV   = 16'd4,
    parameter logic        CPOL      = 1'b0,
    parameter logic        CPHA      = 1'b0,
    parameter logic [7:0]  OKU_KOMUT = 8'h03,
    parameter int          ADRES_BIT = 32,
    parameter int          VERI_BIT  = 32
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        basla_i,
    input  logic [23:0] flash_adres_i,
    input  logic [9:0]  kelime_i,
    output logic        mesgul_o,
    output logic        bitti_o,
    output logic [31:0] veri_o,
    output logic        veri_gecerli_o,
    input  logic        veri_hazir_i,
    spi_flash_okuyucu_if.master bus
);
    typedef enum logic [3:0] {
        BOSTA, CTRL, WDATA, CMD_W, CMD_R, RD_ISTE, RD_BEKLE, CIKIS, BITTI
    } durum_t;

    durum_t               durum;
    durum_t               sonraki;
    logic [23:0]          adres;
    logic [9:0]           kalan;
    logic [9:0]           n_kelime;
    logic [ADRES_BIT-1:0] req_adres;
    logic [VERI_BIT-1:0]  req_veri;
    logic                 req_yaz;

    assign n_kelime = (kelime_i > 10'd512) ? 10'd512 : kelime_i;

    // Request contents per state; kalan still holds N while CMD_R is issued
    always_comb begin
        req_adres = '0;
        req_veri  = '0;
        req_yaz   = 1'b1;
        sonraki   = durum;
        case (durum)
            CTRL: begin
                req_adres = ADRES_BIT'(`SPI_CTRL_REG);
                req_veri  = VERI_BIT'({SCK_DIV, 12'b0, CPOL, CPHA, 1'b0, 1'b1});
                sonraki   = WDATA;
            end
            WDATA: begin
                req_adres = ADRES_BIT'(`SPI_WDATA_REG);
                req_veri  = VERI_BIT'({OKU_KOMUT, adres});
                sonraki   = CMD_W;
            end
            CMD_W: begin
                req_adres = ADRES_BIT'(`SPI_CMD_REG);
                req_veri  = VERI_BIT'(32'h0000_2000);
                sonraki   = CMD_R;
            end
            CMD_R: begin
                req_adres = ADRES_BIT'(`SPI_CMD_REG);
                req_veri  = VERI_BIT'({18'b0, 2'b01, 2'b0, 1'b1, 9'(kalan - 10'd1)});
                sonraki   = RD_ISTE;
            end
            RD_ISTE: begin
                req_adres = ADRES_BIT'(`SPI_RDATA_REG);
                req_yaz   = 1'b0;
                sonraki   = RD_BEKLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durum           <= BOSTA;
            adres           <= '0;
            kalan           <= '0;
            mesgul_o        <= 1'b0;
            bitti_o         <= 1'b0;
            veri_o          <= '0;
            veri_gecerli_o  <= 1'b0;
            bus.cek_adres   <= '0;
            bus.cek_veri    <= '0;
            bus.cek_yaz     <= 1'b0;
            bus.cek_gecerli <= 1'b0;
            bus.spi_hazir   <= 1'b0;
        end else begin
            bitti_o <= 1'b0;
            case (durum)
                BOSTA: begin
                    if (basla_i) begin
                        adres    <= flash_adres_i;
                        kalan    <= n_kelime;
                        mesgul_o <= 1'b1;
                        durum    <= (n_kelime == 10'd0) ? BITTI : CTRL;
                    end
                end
                // Valid rises one cycle after entry, which also gives the idle gap after the previous acceptance
                CTRL, WDATA, CMD_W, CMD_R, RD_ISTE: begin
                    if (!bus.cek_gecerli) begin
                        bus.cek_gecerli <= 1'b1;
                        bus.cek_adres   <= req_adres;
                        bus.cek_veri    <= req_veri;
                        bus.cek_yaz     <= req_yaz;
                    end else if (bus.cek_hazir) begin
                        bus.cek_gecerli <= 1'b0;
                        durum           <= sonraki;
                        if (durum == RD_ISTE) begin
                            bus.spi_hazir <= 1'b1;
                        end
                    end
                end
                RD_BEKLE: begin
                    if (bus.spi_gecerli && bus.spi_hazir) begin
                        bus.spi_hazir  <= 1'b0;
                        veri_o         <= 32'(bus.spi_veri);
                        veri_gecerli_o <= 1'b1;
                        kalan          <= kalan - 10'd1;
                        durum          <= CIKIS;
                    end
                end
                CIKIS: begin
                    if (veri_gecerli_o && veri_hazir_i) begin
                        veri_gecerli_o <= 1'b0;
                        durum          <= (kalan != 10'd0) ? RD_ISTE : BITTI;
                    end
                end
                BITTI: begin
                    bitti_o  <= 1'b1;
                    mesgul_o <= 1'b0;
                    durum    <= BOSTA;
                end
                default: durum <= BOSTA;
            endcase
        end
    end
endmodule
